// File: rtl/peak_topn_finder.sv
// Purpose: per-frame local-maximum detector keeping the NUM_PEAKS largest peaks, sorted descending.
// Latency: last sample accepted in cycle t -> first out_valid in cycle t+2; one record per handshake.
// Backpressure: in_ready drops from end of frame until the final record is taken; records hold while out_ready=0.
module peak_topn_finder #(
  parameter int                     VALUE_WIDTH = 16,
  parameter int                     INDEX_WIDTH = 12,
  parameter int                     NUM_PEAKS   = 4,
  parameter logic [VALUE_WIDTH-1:0] THRESHOLD   = '0,
  parameter int                     OUT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   valid,
  output logic                   in_ready,
  input  logic                   last,
  input  logic [VALUE_WIDTH-1:0] input_i,
  input  logic [INDEX_WIDTH-1:0] index_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   p_i_s,
  output logic                   last_out,
  output logic [4:0]             peak_cnt
);

  localparam logic [1:0] ST_SCAN  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;
  localparam int         PW       = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam logic [VALUE_WIDTH:0] THR_EXT = {1'b0, THRESHOLD};

  logic [1:0]             state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [VALUE_WIDTH-1:0] win_l_q, win_l_d, win_m_q, win_m_d, win_r_q, win_r_d;
  logic [INDEX_WIDTH-1:0] idx_m_q, idx_m_d, idx_r_q, idx_r_d;
  logic [1:0]             win_cnt_q, win_cnt_d;
  logic                   eval_q, eval_d;
  logic [4:0]             fill_q, fill_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;

  logic [VALUE_WIDTH-1:0] lst_val_q  [NUM_PEAKS];
  logic [VALUE_WIDTH-1:0] lst_val_d  [NUM_PEAKS];
  logic                   lst_side_q [NUM_PEAKS];
  logic                   lst_side_d [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] lst_idx_q  [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] lst_idx_d  [NUM_PEAKS];

  // Entry i shifted down from i-1; slot 0 never takes a shifted value.
  logic [VALUE_WIDTH-1:0] sh_val  [NUM_PEAKS];
  logic                   sh_side [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] sh_idx  [NUM_PEAKS];

  logic                   accept;
  logic                   thr_ok;
  logic                   is_peak;
  logic                   cand_side;
  logic [VALUE_WIDTH:0]   m_plus_one;
  logic [NUM_PEAKS-1:0]   ge;
  logic [NUM_PEAKS-1:0]   prev_ge;
  logic                   last_entry;
  logic [OUT_WIDTH-1:0]   p_word;

  assign accept    = valid && in_ready_q;
  // m >= T expressed as m+1 > T so a zero threshold still yields a real compare.
  assign m_plus_one = {1'b0, win_m_q} + {{VALUE_WIDTH{1'b0}}, 1'b1};
  assign thr_ok    = (m_plus_one > THR_EXT);
  assign is_peak   = eval_q && (win_m_q > win_l_q) && (win_m_q >= win_r_q) && thr_ok;
  assign cand_side = (win_r_q > win_l_q);

  // Rank the candidate: ge marks filled entries that stay above it (equal values stay ahead).
  always_comb begin
    ge      = '0;
    prev_ge = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      ge[i]   = (5'(i) < fill_q) && (lst_val_q[i] >= win_m_q);
      sh_val[i]  = '0;
      sh_side[i] = 1'b0;
      sh_idx[i]  = '0;
    end
    prev_ge[0] = 1'b1;
    for (int i = 1; i < NUM_PEAKS; i++) begin
      prev_ge[i] = ge[i-1];
      sh_val[i]  = lst_val_q[i-1];
      sh_side[i] = lst_side_q[i-1];
      sh_idx[i]  = lst_idx_q[i-1];
    end
  end

  // Window shift, sorted insertion and frame sequencing.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    win_l_d    = win_l_q;
    win_m_d    = win_m_q;
    win_r_d    = win_r_q;
    idx_m_d    = idx_m_q;
    idx_r_d    = idx_r_q;
    win_cnt_d  = win_cnt_q;
    eval_d     = 1'b0;
    lst_val_d  = lst_val_q;
    lst_side_d = lst_side_q;
    lst_idx_d  = lst_idx_q;

    if (accept) begin
      win_l_d   = win_m_q;
      win_m_d   = win_r_q;
      win_r_d   = input_i;
      idx_m_d   = idx_r_q;
      idx_r_d   = index_i;
      // The middle sample has both neighbours once two samples preceded this one.
      eval_d    = (win_cnt_q == 2'd2);
      win_cnt_d = (win_cnt_q == 2'd2) ? 2'd2 : win_cnt_q + 2'd1;
    end

    // A candidate fits if some slot is not held by an entry >= it.
    if (is_peak && !ge[NUM_PEAKS-1]) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        if (!ge[i]) begin
          if (prev_ge[i]) begin
            lst_val_d[i]  = win_m_q;
            lst_side_d[i] = cand_side;
            lst_idx_d[i]  = idx_m_q;
          end else begin
            lst_val_d[i]  = sh_val[i];
            lst_side_d[i] = sh_side[i];
            lst_idx_d[i]  = sh_idx[i];
          end
        end
      end
      if (fill_q < 5'(NUM_PEAKS)) begin
        fill_d = fill_q + 5'd1;
      end
    end

    case (state_q)
      ST_SCAN: begin
        if (accept && last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d  = ST_DUMP;
        rd_ptr_d = '0;
      end
      ST_DUMP: begin
        if (out_ready) begin
          if (last_entry) begin
            state_d   = ST_SCAN;
            rd_ptr_d  = '0;
            fill_d    = '0;
            win_l_d   = '0;
            win_m_d   = '0;
            win_r_d   = '0;
            idx_m_d   = '0;
            idx_r_d   = '0;
            win_cnt_d = '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              lst_val_d[i]  = '0;
              lst_side_d[i] = 1'b0;
              lst_idx_d[i]  = '0;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase

    in_ready_d = (state_d == ST_SCAN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_SCAN;
      in_ready_q <= 1'b0;
      win_l_q    <= '0;
      win_m_q    <= '0;
      win_r_q    <= '0;
      idx_m_q    <= '0;
      idx_r_q    <= '0;
      win_cnt_q  <= '0;
      eval_q     <= 1'b0;
      fill_q     <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        lst_val_q[i]  <= '0;
        lst_side_q[i] <= 1'b0;
        lst_idx_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      win_l_q    <= win_l_d;
      win_m_q    <= win_m_d;
      win_r_q    <= win_r_d;
      idx_m_q    <= idx_m_d;
      idx_r_q    <= idx_r_d;
      win_cnt_q  <= win_cnt_d;
      eval_q     <= eval_d;
      fill_q     <= fill_d;
      rd_ptr_q   <= rd_ptr_d;
      lst_val_q  <= lst_val_d;
      lst_side_q <= lst_side_d;
      lst_idx_q  <= lst_idx_d;
    end
  end

  // Record packing; an empty list dumps a single all-zero word.
  always_comb begin
    p_word = '0;
    if ((state_q == ST_DUMP) && (fill_q != 5'd0)) begin
      p_word[OUT_WIDTH-1 -: VALUE_WIDTH]   = lst_val_q[rd_ptr_q];
      p_word[OUT_WIDTH-1-VALUE_WIDTH]      = lst_side_q[rd_ptr_q];
      p_word[INDEX_WIDTH-1:0]              = lst_idx_q[rd_ptr_q];
    end
  end

  assign last_entry = (fill_q == 5'd0) || ((5'(rd_ptr_q) + 5'd1) == fill_q);
  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == ST_DUMP);
  assign last_out   = (state_q == ST_DUMP) && last_entry;
  assign p_i_s      = p_word;
  assign peak_cnt   = fill_q;

endmodule

// File: tb/tb_peak_topn_finder.sv
// Bench for peak_topn_finder: two instances (THRESHOLD 0 and 100) share the input stream.
// Expected records come from a list-based model of the peak/sort rules.
// Each scenario task drives frames, gathers dump records and compares inline.
module tb_peak_topn_finder;

  typedef logic [32:0] rec_q_t [$];
  typedef int unsigned val_q_t [$];

  logic        clk = 1'b0;
  logic        aresetn;
  logic        valid;
  logic        last;
  logic [15:0] input_i;
  logic [11:0] index_i;
  logic        out_ready;

  logic        in_ready0, out_valid0, last_out0;
  logic [31:0] p_i_s0;
  logic [4:0]  peak_cnt0;
  logic        in_ready1, out_valid1, last_out1;
  logic [31:0] p_i_s1;
  logic [4:0]  peak_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  peak_topn_finder dut (
    .clk(clk), .aresetn(aresetn), .valid(valid), .in_ready(in_ready0), .last(last),
    .input_i(input_i), .index_i(index_i), .out_valid(out_valid0), .out_ready(out_ready),
    .p_i_s(p_i_s0), .last_out(last_out0), .peak_cnt(peak_cnt0)
  );

  peak_topn_finder #(.THRESHOLD(16'd100)) dut_thr (
    .clk(clk), .aresetn(aresetn), .valid(valid), .in_ready(in_ready1), .last(last),
    .input_i(input_i), .index_i(index_i), .out_valid(out_valid1), .out_ready(out_ready),
    .p_i_s(p_i_s1), .last_out(last_out1), .peak_cnt(peak_cnt1)
  );

  // Reference: find all local maxima, then pick the 4 largest (earliest arrival wins ties).
  function automatic void build_exp(input val_q_t v, input int unsigned base, input int unsigned thr,
                                    output rec_q_t exp, output int cnt);
    int unsigned cv[$];
    int unsigned cs[$];
    int unsigned ci[$];
    bit          used[$];
    int          n;
    int          best;
    logic [32:0] w;
    exp = {};
    n   = v.size();
    for (int k = 1; k < n - 1; k++) begin
      if (v[k] > v[k-1] && v[k] >= v[k+1] && v[k] >= thr) begin
        cv.push_back(v[k]);
        cs.push_back((v[k+1] > v[k-1]) ? 1 : 0);
        ci.push_back((base + k) % 4096);
        used.push_back(1'b0);
      end
    end
    for (int r = 0; r < 4; r++) begin
      best = -1;
      for (int j = 0; j < cv.size(); j++)
        if (!used[j] && (best < 0 || cv[j] > cv[best])) best = j;
      if (best < 0) break;
      used[best] = 1'b1;
      w = '0;
      w[31:16] = cv[best][15:0];
      w[15]    = cs[best][0];
      w[11:0]  = ci[best][11:0];
      exp.push_back(w);
    end
    cnt = exp.size();
    if (cnt == 0) exp.push_back({1'b1, 32'h0});
    else begin
      w = exp[cnt-1];
      w[32] = 1'b1;
      exp[cnt-1] = w;
    end
  endfunction

  function automatic val_q_t rand_frame(input int len, input int unsigned maxv);
    val_q_t v;
    v = {};
    for (int k = 0; k < len; k++) v.push_back($urandom_range(0, maxv));
    return v;
  endfunction

  // Streams one frame into both instances; gap>0 inserts an idle slot every gap-th slot.
  task automatic send_frame(input val_q_t v, input int unsigned base, input int gap, output int t_last);
    int waited = 0;
    int k = 0;
    int slot = 0;
    t_last = -1;
    @(posedge clk); #1;
    while (!(in_ready0 && in_ready1) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (waited >= 200) begin
      n_fail++;
      $display("FAIL frame_start_ready: in_ready0=%0b in_ready1=%0b, required 1 within 200 cycles", in_ready0, in_ready1);
    end
    while (k < v.size()) begin
      if (gap > 0 && (slot % gap) == gap - 1) begin
        valid   = 1'b0;
        last    = 1'($urandom_range(0, 1));
        input_i = 16'($urandom);
      end else begin
        valid   = 1'b1;
        input_i = v[k][15:0];
        index_i = 12'((base + k) % 4096);
        last    = (k == v.size() - 1);
        if (last) t_last = cyc;
        k++;
      end
      slot++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  // Drives out_ready (0: always, 1: toggle, 2: random) and gathers records of both instances.
  task automatic collect(input int mode, output rec_q_t r0, output rec_q_t r1, output int pc0, output int pc1,
                         output int first0, output int stab_err, output int inrdy_err, output int timeout);
    bit          done0 = 0, done1 = 0;
    bit          pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
    logic [32:0] pp0 = '0, pp1 = '0;
    r0 = {}; r1 = {};
    pc0 = -1; pc1 = -1; first0 = -1; stab_err = 0; inrdy_err = 0;
    for (int c = 0; c < 400 && !(done0 && done1); c++) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : 1'($urandom_range(0, 1));
      if (out_valid0) begin
        if (first0 < 0) begin first0 = cyc; pc0 = peak_cnt0; end
        if (in_ready0) inrdy_err++;
        if (peak_cnt0 != 5'(pc0)) stab_err++;
        if (pv0 && !pr0 && {last_out0, p_i_s0} !== pp0) stab_err++;
        if (out_ready && !done0) begin
          r0.push_back({last_out0, p_i_s0});
          if (last_out0) done0 = 1;
        end
      end
      if (out_valid1) begin
        if (pc1 < 0) pc1 = peak_cnt1;
        if (in_ready1) inrdy_err++;
        if (peak_cnt1 != 5'(pc1)) stab_err++;
        if (pv1 && !pr1 && {last_out1, p_i_s1} !== pp1) stab_err++;
        if (out_ready && !done1) begin
          r1.push_back({last_out1, p_i_s1});
          if (last_out1) done1 = 1;
        end
      end
      pv0 = out_valid0; pr0 = out_ready; pp0 = {last_out0, p_i_s0};
      pv1 = out_valid1; pr1 = out_ready; pp1 = {last_out1, p_i_s1};
    end
    timeout = !(done0 && done1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; valid = 1'b0; last = 1'b0; input_i = '0; index_i = '0; out_ready = 1'b0;
    #1;
    n_checks++;
    if ({in_ready0, out_valid0, last_out0, p_i_s0, peak_cnt0} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_thr0: in_ready=%0b out_valid=%0b last_out=%0b p_i_s=%h peak_cnt=%0d, required all 0",
               in_ready0, out_valid0, last_out0, p_i_s0, peak_cnt0);
    end
    n_checks++;
    if ({in_ready1, out_valid1, last_out1, p_i_s1, peak_cnt1} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_thr100: in_ready=%0b out_valid=%0b last_out=%0b p_i_s=%h peak_cnt=%0d, required all 0",
               in_ready1, out_valid1, last_out1, p_i_s1, peak_cnt1);
    end
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_scan: in_ready=%0b out_valid=%0b, required 1/0", in_ready0, out_valid0);
    end
  endtask

  // Runs a list of frames with a given gap/ready mode and checks everything per frame.
  task automatic run_frames(input string name, input val_q_t frames[$], input int gap, input int mode);
    rec_q_t r0, r1, e0, e1, got, exp;
    int pc0, pc1, c0, c1, first0, serr, ierr, tout, t_last, gc, ec;
    for (int f = 0; f < frames.size(); f++) begin
      send_frame(frames[f], 0, gap, t_last);
      collect(mode, r0, r1, pc0, pc1, first0, serr, ierr, tout);
      build_exp(frames[f], 0, 0, e0, c0);
      build_exp(frames[f], 0, 100, e1, c1);
      for (int d = 0; d < 2; d++) begin
        got = d ? r1 : r0;
        exp = d ? e1 : e0;
        gc  = d ? pc1 : pc0;
        ec  = d ? c1 : c0;
        n_checks++;
        if (got.size() != exp.size()) begin
          n_fail++;
          $display("FAIL %s_f%0d_d%0d_count: got %0d records, required %0d", name, f, d, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
          n_checks++;
          if (got[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL %s_f%0d_d%0d_rec%0d: got {last,word}=%h, required %h", name, f, d, i, got[i], exp[i]);
          end
        end
        n_checks++;
        if (gc != ec) begin
          n_fail++;
          $display("FAIL %s_f%0d_d%0d_peak_cnt: got %0d, required %0d", name, f, d, gc, ec);
        end
      end
      n_checks++;
      if (first0 != t_last + 2) begin
        n_fail++;
        $display("FAIL %s_f%0d_latency: first out_valid cycle %0d, required %0d", name, f, first0, t_last + 2);
      end
      n_checks++;
      if (serr != 0 || ierr != 0 || tout != 0) begin
        n_fail++;
        $display("FAIL %s_f%0d_dump_protocol: stable_err=%0d in_ready_err=%0d timeout=%0d, required 0/0/0",
                 name, f, serr, ierr, tout);
      end
    end
  endtask

  task automatic test_directed;
    val_q_t fr[$];
    fr = {};
    fr.push_back('{'h4, 'h28, 'h34, 'hA34, 'h137, 'h84, 'h1E3, 'h98});
    fr.push_back('{'h10, 'h50, 'h10, 'h60, 'h10, 'h70, 'h10, 'h80, 'h10, 'h90, 'h10});
    fr.push_back('{1, 5, 1, 5, 1, 7, 7, 1});
    fr.push_back('{1, 50, 1, 200, 1});
    fr.push_back('{3, 2, 1});
    fr.push_back('{9});
    fr.push_back('{2, 9});
    run_frames("directed", fr, 0, 0);
  endtask

  task automatic test_back_to_back;
    val_q_t fr[$];
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(rand_frame($urandom_range(3, 24), (i % 2) ? 15 : 400));
    run_frames("random", fr, 0, 2);
  endtask

  task automatic test_gaps_backpressure;
    val_q_t fr[$];
    fr = {};
    fr.push_back('{'h4, 'h28, 'h34, 'hA34, 'h137, 'h84, 'h1E3, 'h98});
    for (int i = 0; i < 4; i++) fr.push_back(rand_frame($urandom_range(5, 30), (i % 2) ? 20 : 300));
    run_frames("gaps", fr, 7, 1);
  endtask

  task automatic test_reset_mid_dump;
    val_q_t v, v2;
    rec_q_t r0, r1, e0, e1;
    int pc0, pc1, c0, c1, first0, serr, ierr, tout, t_last, waited;
    v = '{10, 50, 10, 60, 10, 70, 10};
    send_frame(v, 0, 0, t_last);
    waited = 0;
    @(negedge clk);
    while (!out_valid0 && waited < 50) begin @(negedge clk); waited++; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid0 !== 1'b1 || last_out0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_dump_before_reset: out_valid=%0b last_out=%0b, required 1/0", out_valid0, last_out0);
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0 || p_i_s0 !== 32'h0 || peak_cnt0 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dump: out_valid=%0b in_ready=%0b p_i_s=%h peak_cnt=%0d, required 0/0/0/0",
               out_valid0, in_ready0, p_i_s0, peak_cnt0);
    end
    @(negedge clk);
    aresetn = 1'b1;
    v2 = '{5, 120, 5, 30, 5};
    send_frame(v2, 40, 0, t_last);
    collect(0, r0, r1, pc0, pc1, first0, serr, ierr, tout);
    build_exp(v2, 40, 0, e0, c0);
    build_exp(v2, 40, 100, e1, c1);
    n_checks++;
    if (r0 != e0 || pc0 != c0) begin
      n_fail++;
      $display("FAIL after_reset_frame_thr0: got %0d records (first %h) cnt %0d, required %0d records (first %h) cnt %0d",
               r0.size(), (r0.size() > 0) ? r0[0] : 33'h0, pc0, e0.size(), e0[0], c0);
    end
    n_checks++;
    if (r1 != e1 || pc1 != c1 || tout != 0) begin
      n_fail++;
      $display("FAIL after_reset_frame_thr100: got %0d records cnt %0d timeout %0d, required %0d records cnt %0d",
               r1.size(), pc1, tout, e1.size(), c1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_gaps_backpressure();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
